// File: rtl/breakout_game_engine.sv
// Breakout per-frame game-state engine.
// Each accepted frame_tick runs one update: paddle move, ball move with
// wall/paddle handling, a serial one-brick-per-cycle scan, then commit.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   frame_tick               one-cycle end-of-frame pulse
//   start                    serve / begin play (level)
//   move_left, move_right    paddle requests (level)
//   ball_x, ball_y           ball top-left corner
//   paddle_x, paddle_y       paddle top-left corner (paddle_y constant)
//   hit                      sticky brick-destroyed flags, bit row*8+col
//   score, lives             bricks destroyed, remaining lives
//   game_over, game_won      terminal phase flags
//   busy                     update in progress
//   frame_done               one-cycle pulse when an update finishes
module breakout_game_engine #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int BALL_SIZE    = 10,
    parameter int BALL_SPEED   = 2,
    parameter int BALL_X0      = 300,
    parameter int BALL_Y0      = 300,
    parameter int PADDLE_W     = 160,
    parameter int PADDLE_H     = 10,
    parameter int PADDLE_Y     = 440,
    parameter int PADDLE_X0    = 240,
    parameter int PADDLE_SPEED = 4,
    parameter int BRICK_W      = 80,
    parameter int BRICK_H      = 40,
    parameter int ROW0_Y       = 20,
    parameter int ROW_PITCH    = 50,
    parameter int LIVES0       = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        move_left,
    input  logic        move_right,
    output logic [9:0]  ball_x,
    output logic [9:0]  ball_y,
    output logic [9:0]  paddle_x,
    output logic [9:0]  paddle_y,
    output logic [23:0] hit,
    output logic [4:0]  score,
    output logic [1:0]  lives,
    output logic        game_over,
    output logic        game_won,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [2:0] {IDLE, WAIT, MOVE, SCAN, COMMIT, MISS, OVER, WIN} state_t;
    state_t state;

    localparam logic signed [10:0] SPD     = 11'(BALL_SPEED);
    localparam logic signed [10:0] X_MAX   = 11'(SCREEN_W - BALL_SIZE);
    localparam logic signed [10:0] Y_MAX   = 11'(SCREEN_H - BALL_SIZE);
    localparam logic [9:0]         PAD_MAX = 10'(SCREEN_W - PADDLE_W);
    localparam logic [9:0]         PAD_SPD = 10'(PADDLE_SPEED);
    localparam logic [10:0]        BSZ     = 11'(BALL_SIZE);

    // Direction flags: 1 = negative direction.
    logic       dx_neg, dy_neg, ndx_neg, ndy_neg;
    // Candidate position held from MOVE until COMMIT.
    logic [9:0] nx, ny;
    logic [4:0] idx;

    logic [9:0]         paddle_next;
    logic signed [10:0] cx, cy;
    logic [9:0]         mv_nx, mv_ny;
    logic               mv_dx_neg, mv_dy_neg, mv_miss;
    logic [10:0]        pad_l, mx, my;
    logic [2:0]         col;
    logic [1:0]         row;
    logic [10:0]        brick_x, brick_y, sx, sy;
    logic               brick_hit;

    assign paddle_y = 10'(PADDLE_Y);

    always_comb begin
        paddle_next = paddle_x;
        if (move_left && !move_right)
            paddle_next = (paddle_x < PAD_SPD) ? '0 : paddle_x - PAD_SPD;
        else if (move_right && !move_left)
            paddle_next = (paddle_x > PAD_MAX - PAD_SPD) ? PAD_MAX : paddle_x + PAD_SPD;
    end

    // Ball step, wall clamps and paddle bounce against the new paddle position.
    always_comb begin
        cx        = $signed({1'b0, ball_x}) + (dx_neg ? -SPD : SPD);
        cy        = $signed({1'b0, ball_y}) + (dy_neg ? -SPD : SPD);
        mv_dx_neg = dx_neg;
        mv_dy_neg = dy_neg;
        mv_nx     = cx[9:0];
        mv_ny     = cy[9:0];
        if (cx < 0) begin
            mv_nx     = '0;
            mv_dx_neg = 1'b0;
        end else if (cx > X_MAX) begin
            mv_nx     = X_MAX[9:0];
            mv_dx_neg = 1'b1;
        end
        if (cy < 0) begin
            mv_ny     = '0;
            mv_dy_neg = 1'b0;
        end
        mv_miss = cy > Y_MAX;
        pad_l   = {1'b0, paddle_next};
        mx      = {1'b0, mv_nx};
        my      = {1'b0, mv_ny};
        if (!mv_miss && !mv_dy_neg
            && mx < pad_l + 11'(PADDLE_W) && mx + BSZ > pad_l
            && my < 11'(PADDLE_Y + PADDLE_H) && my + BSZ > 11'(PADDLE_Y)) begin
            mv_ny     = 10'(PADDLE_Y - BALL_SIZE);
            mv_dy_neg = 1'b1;
            mv_dx_neg = (mx + 11'(BALL_SIZE / 2)) < (pad_l + 11'(PADDLE_W / 2));
        end
    end

    // Brick under test this SCAN cycle: row = idx/8, col = idx%8.
    always_comb begin
        row       = idx[4:3];
        col       = idx[2:0];
        brick_x   = 11'(col) * 11'(BRICK_W);
        brick_y   = 11'(ROW0_Y) + 11'(row) * 11'(ROW_PITCH);
        sx        = {1'b0, nx};
        sy        = {1'b0, ny};
        brick_hit = !hit[idx]
                    && sx < brick_x + 11'(BRICK_W) && sx + BSZ > brick_x
                    && sy < brick_y + 11'(BRICK_H) && sy + BSZ > brick_y;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ball_x     <= 10'(BALL_X0);
            ball_y     <= 10'(BALL_Y0);
            paddle_x   <= 10'(PADDLE_X0);
            dx_neg     <= 1'b0;
            dy_neg     <= 1'b1;
            ndx_neg    <= 1'b0;
            ndy_neg    <= 1'b1;
            nx         <= '0;
            ny         <= '0;
            idx        <= '0;
            hit        <= '0;
            score      <= '0;
            lives      <= 2'(LIVES0);
            game_over  <= 1'b0;
            game_won   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    ball_x <= 10'(BALL_X0);
                    ball_y <= 10'(BALL_Y0);
                    dy_neg <= 1'b1;
                    if (frame_tick) paddle_x <= paddle_next;
                    if (start) state <= WAIT;
                end
                WAIT: begin
                    if (frame_tick) begin
                        busy  <= 1'b1;
                        state <= MOVE;
                    end
                end
                MOVE: begin
                    paddle_x <= paddle_next;
                    nx       <= mv_nx;
                    ny       <= mv_ny;
                    ndx_neg  <= mv_dx_neg;
                    ndy_neg  <= mv_dy_neg;
                    idx      <= '0;
                    state    <= mv_miss ? MISS : SCAN;
                end
                SCAN: begin
                    // First untouched overlapping brick ends the scan.
                    if (brick_hit) begin
                        hit[idx] <= 1'b1;
                        score    <= score + 5'd1;
                        ndy_neg  <= ~ndy_neg;
                        state    <= COMMIT;
                    end else if (idx == 5'd23) begin
                        state <= COMMIT;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                COMMIT: begin
                    ball_x     <= nx;
                    ball_y     <= ny;
                    dx_neg     <= ndx_neg;
                    dy_neg     <= ndy_neg;
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    if (&hit) begin
                        game_won <= 1'b1;
                        state    <= WIN;
                    end else begin
                        state <= WAIT;
                    end
                end
                MISS: begin
                    lives      <= lives - 2'd1;
                    ball_x     <= 10'(BALL_X0);
                    ball_y     <= 10'(BALL_Y0);
                    dx_neg     <= 1'b0;
                    dy_neg     <= 1'b1;
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                    if (lives == 2'd1) begin
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else begin
                        state <= IDLE;
                    end
                end
                OVER, WIN: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_breakout_game_engine.sv
// Testbench for breakout_game_engine: reset checks, a table of paddle
// vectors, clamp/reset/terminal-state sequences, and randomized play
// compared frame by frame against a rule-level model of the game.
module tb_breakout_game_engine;

    logic        clk = 1'b0;
    logic        rst, frame_tick, start, move_left, move_right;
    logic [9:0]  ball_x, ball_y, paddle_x, paddle_y;
    logic [23:0] hit;
    logic [4:0]  score;
    logic [1:0]  lives;
    logic        game_over, game_won, busy, frame_done;

    always #5 clk = ~clk;

    breakout_game_engine dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
        .move_left(move_left), .move_right(move_right),
        .ball_x(ball_x), .ball_y(ball_y), .paddle_x(paddle_x), .paddle_y(paddle_y),
        .hit(hit), .score(score), .lives(lives), .game_over(game_over),
        .game_won(game_won), .busy(busy), .frame_done(frame_done)
    );

    int errors = 0;
    int checks = 0;

    typedef enum {PH_IDLE, PH_WAIT, PH_OVER, PH_WIN} phase_t;
    phase_t      m_phase;
    int          m_bx, m_by, m_dx, m_dy, m_px, m_score, m_lives;
    logic [23:0] m_hit;

    typedef struct {
        bit l;
        bit r;
        int exp_px;
    } pvec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit ovl(input int ax, input int ay, input int aw, input int ah,
                               input int bx, input int by, input int bw, input int bh);
        return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
    endfunction

    function automatic int pmove(input int px, input bit l, input bit r);
        if (l && !r) return (px - 4 < 0) ? 0 : px - 4;
        if (r && !l) return (px + 4 > 480) ? 480 : px + 4;
        return px;
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_bx = 300; m_by = 300; m_dx = 1; m_dy = -1;
        m_px = 240; m_score = 0; m_lives = 3; m_hit = '0;
    endtask

    task automatic model_frame(input bit l, input bit r);
        int nx, ny, ndx, ndy;
        if (m_phase == PH_IDLE) begin
            m_px = pmove(m_px, l, r);
        end else if (m_phase == PH_WAIT) begin
            m_px = pmove(m_px, l, r);
            nx = m_bx + 2 * m_dx; ny = m_by + 2 * m_dy; ndx = m_dx; ndy = m_dy;
            if (nx < 0) begin nx = 0; ndx = 1; end
            else if (nx > 630) begin nx = 630; ndx = -1; end
            if (ny < 0) begin ny = 0; ndy = 1; end
            if (ny > 470) begin
                m_lives--;
                m_bx = 300; m_by = 300; m_dx = 1; m_dy = -1;
                m_phase = (m_lives == 0) ? PH_OVER : PH_IDLE;
            end else begin
                if (ndy == 1 && ovl(nx, ny, 10, 10, m_px, 440, 160, 10)) begin
                    ny = 430; ndy = -1;
                    ndx = (nx + 5 < m_px + 80) ? -1 : 1;
                end
                for (int i = 0; i < 24; i++) begin
                    if (!m_hit[i] && ovl(nx, ny, 10, 10, (i % 8) * 80, 20 + (i / 8) * 50, 80, 40)) begin
                        m_hit[i] = 1'b1;
                        m_score++;
                        ndy = -ndy;
                        break;
                    end
                end
                m_bx = nx; m_by = ny; m_dx = ndx; m_dy = ndy;
                m_phase = (m_hit == 24'hFF_FFFF) ? PH_WIN : PH_WAIT;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".ball_x"}, ball_x, m_bx);
        chk({tag, ".ball_y"}, ball_y, m_by);
        chk({tag, ".paddle_x"}, paddle_x, m_px);
        chk({tag, ".paddle_y"}, paddle_y, 440);
        chk({tag, ".hit"}, hit, m_hit);
        chk({tag, ".score"}, score, m_score);
        chk({tag, ".lives"}, lives, m_lives);
        chk({tag, ".game_over"}, game_over, (m_phase == PH_OVER) ? 1 : 0);
        chk({tag, ".game_won"}, game_won, (m_phase == PH_WIN) ? 1 : 0);
        chk({tag, ".busy"}, busy, 0);
    endtask

    // One frame: tick, optional second tick while busy, bounded wait, compare.
    task automatic do_frame(input string tag, input bit l, input bit r, input bit extra);
        int  ndone, lat;
        bit  was_wait, busy1;
        was_wait = (m_phase == PH_WAIT);
        ndone = 0; lat = -1; busy1 = 1'b0;
        move_left = l; move_right = r;
        frame_tick = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (k == 1) begin
                frame_tick = extra & was_wait;
                busy1 = busy;
            end
            if (k == 2) frame_tick = 1'b0;
            if (frame_done) begin
                ndone++;
                if (lat < 0) lat = k - 1;
            end
        end
        model_frame(l, r);
        if (was_wait) begin
            chk({tag, ".busy_after_tick"}, busy1, 1);
            chk({tag, ".frame_done_count"}, ndone, 1);
            chk({tag, ".latency_within_26"}, (lat >= 1 && lat <= 26) ? lat : -1, lat);
        end else begin
            chk({tag, ".frame_done_count"}, ndone, 0);
        end
        compare_all(tag);
    endtask

    task automatic press_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (m_phase == PH_IDLE) m_phase = PH_WAIT;
        chk("start.busy", busy, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        compare_all("reset");
        chk("reset.frame_done", frame_done, 0);
        rst = 1'b0;
    endtask

    initial begin
        pvec_t tbl[8];
        bit    l, r, extra;
        int    pc, bc, frames;

        tbl = '{'{1, 0, 236}, '{1, 0, 232}, '{1, 1, 232}, '{0, 0, 232},
                '{0, 1, 236}, '{0, 1, 240}, '{0, 1, 244}, '{1, 0, 240}};

        rst = 1'b1; frame_tick = 1'b0; start = 1'b0;
        move_left = 1'b0; move_right = 1'b0;
        @(negedge clk);
        do_reset();

        // Paddle vectors in IDLE.
        for (int i = 0; i < 8; i++) begin
            do_frame("tbl", tbl[i].l, tbl[i].r, 1'b0);
            chk("tbl.paddle_x", paddle_x, tbl[i].exp_px);
        end

        // Clamp at both edges, both-held hold.
        for (int i = 0; i < 70; i++) do_frame("clamp_left", 1'b1, 1'b0, 1'b0);
        chk("clamp_left.final", paddle_x, 0);
        for (int i = 0; i < 130; i++) do_frame("clamp_right", 1'b0, 1'b1, 1'b0);
        chk("clamp_right.final", paddle_x, 480);
        for (int i = 0; i < 3; i++) do_frame("both_held", 1'b1, 1'b1, 1'b0);
        chk("both_held.final", paddle_x, 480);

        // Reset in the middle of an update: no partial commit, back in IDLE.
        do_reset();
        press_start();
        move_left = 1'b1; move_right = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (8) @(negedge clk);
        chk("midreset.busy_before", busy, 1);
        do_reset();
        do_frame("midreset.idle_frame", 1'b0, 1'b1, 1'b0);

        // Randomized play: tracking first, then steering away to lose lives.
        do_reset();
        frames = 0;
        while (frames < 2000 && (m_phase == PH_IDLE || m_phase == PH_WAIT)) begin
            if (m_phase == PH_IDLE && $urandom_range(3) != 0) press_start();
            pc = m_px + 80;
            bc = m_bx + 5;
            if ($urandom_range(7) == 0) begin
                l = 1'($urandom_range(1)); r = 1'($urandom_range(1));
            end else if (frames < 400) begin
                l = (pc > bc + 6); r = (pc < bc - 6);
            end else begin
                l = (pc < bc); r = !(pc < bc);
            end
            extra = ($urandom_range(3) == 0);
            do_frame("play", l, r, extra);
            frames++;
        end

        // Terminal state ignores start and frame_tick.
        if (m_phase == PH_OVER || m_phase == PH_WIN) begin
            for (int i = 0; i < 3; i++) begin
                press_start();
                do_frame("terminal", 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
            end
            chk("terminal.flag", game_over | game_won, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
